scr1_cnn_mac_slave: RTL and testbench

SCR1_CNN_MAC_SLAVE -- requirements
Module: scr1_cnn_mac_slave

---
 rtl/scr1_memif_pkg.sv | 21 ++
 rtl/scr1_cnn_mac_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_scr1_cnn_mac_slave.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_memif_pkg.sv
// Memory-interface types shared by the data-memory router and its slaves.
package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE   = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage : scr1_memif_pkg

// File: rtl/scr1_cnn_mac_slave.sv
// 3x3 convolution MAC accelerator on a data-memory router port: nine signed
// 8-bit weight/input pairs plus a 32-bit bias, one MAC per cycle.
module scr1_cnn_mac_slave
  import scr1_memif_pkg::*;
#(
  parameter logic [31:0] SCR1_CNN_OFFSET_MASK = 32'h000000FF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dmem_req,
  output logic                 dmem_req_ack,
  input  type_scr1_mem_cmd_e   dmem_cmd,
  input  type_scr1_mem_width_e dmem_width,
  input  logic [31:0]          dmem_addr,
  input  logic [31:0]          dmem_wdata,
  output logic [31:0]          dmem_rdata,
  output type_scr1_mem_resp_e  dmem_resp,
  output logic                 cnn_irq
);

  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_STATUS = 32'h04;
  localparam logic [31:0] OFF_RESULT = 32'h08;
  localparam logic [31:0] OFF_BIAS   = 32'h0C;
  localparam logic [31:0] OFF_W0     = 32'h10;
  localparam logic [31:0] OFF_W8     = 32'h30;
  localparam logic [31:0] OFF_X0     = 32'h40;
  localparam logic [31:0] OFF_X8     = 32'h60;
  localparam logic [3:0]  LAST_IDX   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_RESULT,
    SEL_BIAS,
    SEL_W,
    SEL_X
  } sel_e;

  state_e              state_q, state_d;
  logic                ack_q;
  logic [31:0]         bias_q;
  logic [31:0]         acc_q;
  logic [31:0]         result_q;
  logic [3:0]          idx_q;
  logic signed [7:0]   w_q [9];
  logic signed [7:0]   x_q [9];

  type_scr1_mem_resp_e resp_q;
  logic [31:0]         rdata_q;

  logic [31:0]         offset;
  sel_e                sel;
  logic [3:0]          sel_idx;
  logic                accepted;
  logic                is_wr;
  logic                err;
  logic                wr_ok;
  logic [31:0]         rd_val;
  logic                busy;
  logic                done;
  logic                start_pulse;
  logic                clear_pulse;
  logic                mac_start;
  logic                mac_last;
  logic signed [15:0]  product;
  logic [31:0]         acc_sum;

  assign offset   = dmem_addr & SCR1_CNN_OFFSET_MASK;
  assign accepted = dmem_req & ack_q;
  assign is_wr    = (dmem_cmd == SCR1_MEM_CMD_WR);
  assign busy     = (state_q == ST_BUSY);
  assign done     = (state_q == ST_DONE);

  // Address decode: which register the access targets, and the W/X slot.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case chain can leave it unassigned and infer a latch.
  always_comb begin
    sel     = SEL_NONE;
    sel_idx = '0;
    if (offset == OFF_CTRL) begin
      sel = SEL_CTRL;
    end else if (offset == OFF_STATUS) begin
      sel = SEL_STATUS;
    end else if (offset == OFF_RESULT) begin
      sel = SEL_RESULT;
    end else if (offset == OFF_BIAS) begin
      sel = SEL_BIAS;
    end else if (offset >= OFF_W0 && offset <= OFF_W8 && offset[1:0] == 2'b00) begin
      sel     = SEL_W;
      sel_idx = 4'((offset - OFF_W0) >> 2);
    end else if (offset >= OFF_X0 && offset <= OFF_X8 && offset[1:0] == 2'b00) begin
      sel     = SEL_X;
      sel_idx = 4'((offset - OFF_X0) >> 2);
    end
  end

  // Access legality; a rejected access must leave every register untouched.
  always_comb begin
    err = 1'b0;
    if (dmem_width != SCR1_MEM_WIDTH_WORD || dmem_addr[1:0] != 2'b00 || sel == SEL_NONE) begin
      err = 1'b1;
    end else if (is_wr) begin
      case (sel)
        SEL_STATUS, SEL_RESULT:  err = 1'b1;
        SEL_BIAS, SEL_W, SEL_X:  err = busy;
        default:                 err = 1'b0;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_STATUS: rd_val = {30'b0, done, busy};
      SEL_RESULT: rd_val = result_q;
      SEL_BIAS:   rd_val = bias_q;
      SEL_W:      rd_val = {{24{w_q[sel_idx][7]}}, w_q[sel_idx]};
      SEL_X:      rd_val = {{24{x_q[sel_idx][7]}}, x_q[sel_idx]};
      default:    rd_val = '0;
    endcase
  end

  assign wr_ok       = accepted & is_wr & ~err;
  assign start_pulse = wr_ok & (sel == SEL_CTRL) & dmem_wdata[0];
  assign clear_pulse = wr_ok & (sel == SEL_CTRL) & dmem_wdata[1];

  // 8x8 signed product, sign-extended into the wrapping 32-bit accumulator.
  assign product = w_q[idx_q] * x_q[idx_q];
  assign acc_sum = acc_q + {{16{product[15]}}, product};

  always_comb begin
    state_d   = state_q;
    mac_start = 1'b0;
    mac_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          state_d   = ST_BUSY;
          mac_start = 1'b1;
        end
      end
      ST_BUSY: begin
        if (idx_q == LAST_IDX) begin
          state_d  = ST_DONE;
          mac_last = 1'b1;
        end
      end
      ST_DONE: begin
        // Start takes priority over clear-done in the same CTRL write.
        if (start_pulse) begin
          state_d   = ST_BUSY;
          mac_start = 1'b1;
        end else if (clear_pulse) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RESULT only updates on the final MAC, so an aborted run never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else if (mac_start) begin
      acc_q <= bias_q;
      idx_q <= '0;
    end else if (busy) begin
      acc_q <= acc_sum;
      if (mac_last) begin
        result_q <= acc_sum;
      end else begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  // NOTE: the operand arrays are architecturally visible and must read 0 after
  // reset, so they are reset explicitly rather than left as plain storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_q <= '0;
      for (int i = 0; i < 9; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else if (wr_ok) begin
      case (sel)
        SEL_BIAS: bias_q       <= dmem_wdata;
        SEL_W:    w_q[sel_idx] <= dmem_wdata[7:0];
        SEL_X:    x_q[sel_idx] <= dmem_wdata[7:0];
        default:  ;
      endcase
    end
  end

  // Response stage: one registered reply per accepted request, IDLE otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      resp_q  <= SCR1_MEM_RESP_IDLE;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b1;
      if (accepted) begin
        resp_q  <= err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        rdata_q <= (err || is_wr) ? 32'h0 : rd_val;
      end else begin
        resp_q  <= SCR1_MEM_RESP_IDLE;
        rdata_q <= '0;
      end
    end
  end

  assign dmem_req_ack = ack_q;
  assign dmem_resp    = resp_q;
  assign dmem_rdata   = rdata_q;
  assign cnn_irq      = done;

endmodule : scr1_cnn_mac_slave

// File: tb/tb_scr1_cnn_mac_slave.sv
// Self-checking bench for scr1_cnn_mac_slave: directed scenarios plus random
// register traffic, all compared against a cycle-level register model.
module tb_scr1_cnn_mac_slave;
  import scr1_memif_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 dmem_req = 1'b0;
  logic                 dmem_req_ack;
  type_scr1_mem_cmd_e   dmem_cmd = SCR1_MEM_CMD_RD;
  type_scr1_mem_width_e dmem_width = SCR1_MEM_WIDTH_WORD;
  logic [31:0]          dmem_addr = '0;
  logic [31:0]          dmem_wdata = '0;
  logic [31:0]          dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;
  logic                 cnn_irq;

  always #5 clk = ~clk;

  scr1_cnn_mac_slave #(.SCR1_CNN_OFFSET_MASK(32'h000000FF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dmem_req    (dmem_req),
    .dmem_req_ack(dmem_req_ack),
    .dmem_cmd    (dmem_cmd),
    .dmem_width  (dmem_width),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_resp   (dmem_resp),
    .cnn_irq     (cnn_irq)
  );

  localparam logic [1:0] R_IDLE = 2'b00;
  localparam logic [1:0] R_OK   = 2'b01;
  localparam logic [1:0] R_ER   = 2'b10;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Register-level model: operands, a countdown of remaining busy cycles and
  // the result precomputed at start, published when the countdown expires.
  logic [31:0] m_bias, m_result, m_pending;
  byte         m_w [9];
  byte         m_x [9];
  int          m_busy;
  bit          m_done;
  bit          m_ack;

  task automatic model_reset();
    m_bias = 0; m_result = 0; m_pending = 0;
    m_busy = 0; m_done = 0; m_ack = 0;
    for (int i = 0; i < 9; i++) begin
      m_w[i] = 0;
      m_x[i] = 0;
    end
  endtask

  function automatic logic [31:0] golden();
    logic [31:0] acc = m_bias;
    for (int i = 0; i < 9; i++) begin
      int p = int'(m_w[i]) * int'(m_x[i]);
      acc = acc + 32'(p);
    end
    return acc;
  endfunction

  function automatic void classify(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e width,
                                   input logic [31:0] addr, output bit ok, output logic [31:0] val);
    logic [31:0] off = addr & 32'hFF;
    bit wr = (cmd == SCR1_MEM_CMD_WR);
    bit bsy = (m_busy > 0);
    ok  = 1;
    val = 0;
    if (width != SCR1_MEM_WIDTH_WORD || addr[1:0] != 2'b00) ok = 0;
    else if (off == 0)  val = 0;
    else if (off == 4)  begin val = {30'b0, m_done, bsy}; ok = !wr; end
    else if (off == 8)  begin val = m_result; ok = !wr; end
    else if (off == 12) begin val = m_bias; ok = !(wr && bsy); end
    else if (off >= 16 && off <= 48) begin val = 32'(int'(m_w[int'(off - 16) / 4])); ok = !(wr && bsy); end
    else if (off >= 64 && off <= 96) begin val = 32'(int'(m_x[int'(off - 64) / 4])); ok = !(wr && bsy); end
    else ok = 0;
  endfunction

  // One bus cycle: drive at negedge, step the model across the edge, compare after it.
  task automatic cycle(input bit req, input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e width,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic [1:0] rsp);
    bit acc, ok, pre_busy;
    logic [31:0] val, off;
    @(negedge clk);
    dmem_req = req; dmem_cmd = cmd; dmem_width = width; dmem_addr = addr; dmem_wdata = wdata;
    acc = req && m_ack;
    classify(cmd, width, addr, ok, val);
    pre_busy = (m_busy > 0);
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_result = m_pending;
        m_done = 1;
      end
    end
    if (acc && ok && cmd == SCR1_MEM_CMD_WR) begin
      off = addr & 32'hFF;
      if (off == 0) begin
        if (wdata[0] && !pre_busy) begin
          m_busy = 9; m_pending = golden(); m_done = 0;
        end else if (wdata[1] && !pre_busy && m_done) begin
          m_done = 0;
        end
      end else if (off == 12) m_bias = wdata;
      else if (off >= 16 && off <= 48) m_w[int'(off - 16) / 4] = wdata[7:0];
      else if (off >= 64 && off <= 96) m_x[int'(off - 64) / 4] = wdata[7:0];
    end
    m_ack = 1;
    @(posedge clk);
    #1;
    dmem_req = 1'b0;
    check("req_ack", {31'b0, dmem_req_ack}, {31'b0, m_ack});
    check("cnn_irq", {31'b0, cnn_irq}, {31'b0, m_done});
    if (acc) begin
      check($sformatf("resp addr=%08h", addr), {30'b0, dmem_resp}, {30'b0, ok ? R_OK : R_ER});
      if (ok && cmd == SCR1_MEM_CMD_RD) check($sformatf("rdata addr=%08h", addr), dmem_rdata, val);
    end else begin
      check("resp_idle", {30'b0, dmem_resp}, {30'b0, R_IDLE});
      check("rdata_idle", dmem_rdata, 32'h0);
    end
    rd  = dmem_rdata;
    rsp = dmem_resp;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic [1:0] rsp);
    logic [31:0] t;
    cycle(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, a, d, t, rsp);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] rsp);
    cycle(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, a, 32'h0, d, rsp);
  endtask

  task automatic idle();
    logic [31:0] t;
    logic [1:0]  r;
    cycle(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0, t, r);
  endtask

  // Poll STATUS until done (bounded); returns how many reads showed busy.
  task automatic wait_done(output int busy_reads);
    logic [31:0] v;
    logic [1:0]  r;
    busy_reads = 0;
    for (int n = 0; n < 40; n++) begin
      rd(32'h04, v, r);
      if (v == 32'h1) busy_reads++;
      if (v == 32'h2) break;
    end
    check("done_reached", v, 32'h2);
  endtask

  task automatic load_ops(input logic [31:0] bias, input logic [7:0] w[9], input logic [7:0] x[9]);
    logic [1:0] r;
    wr(32'h0C, bias, r);
    for (int i = 0; i < 9; i++) begin
      wr(32'h10 + 32'(4 * i), {24'h0, w[i]}, r);
      wr(32'h40 + 32'(4 * i), {24'h0, x[i]}, r);
    end
  endtask

  task automatic do_reset_release();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("ack_low_before_edge", {31'b0, dmem_req_ack}, 32'h0);
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, exp_pre;
    logic [1:0]  r;
    logic [7:0]  w[9], x[9];
    int          nb;
    logic [31:0] offs[$] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h20, 32'h30,
                             32'h40, 32'h4C, 32'h60, 32'h34, 32'h3C, 32'h64, 32'h80, 32'hFC};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, dmem_req_ack}, 32'h0);
    check("rst_resp", {30'b0, dmem_resp}, {30'b0, R_IDLE});
    check("rst_rdata", dmem_rdata, 32'h0);
    check("rst_irq", {31'b0, cnn_irq}, 32'h0);
    do_reset_release();

    // Sum of 1..9 with unit weights.
    for (int i = 0; i < 9; i++) begin w[i] = 8'd1; x[i] = 8'(i + 1); end
    load_ops(32'h0, w, x);
    wr(32'h00, 32'h1, r);
    wait_done(nb);
    check("basic_busy_cycles", 32'(nb), 32'd9);
    rd(32'h08, v, r);
    check("basic_result", v, 32'h2D);
    check("basic_irq", {31'b0, cnn_irq}, 32'h1);
    wr(32'h00, 32'h2, r);
    rd(32'h04, v, r);
    check("clear_status", v, 32'h0);

    // Negative weights, sign extension on readback.
    for (int i = 0; i < 9; i++) begin w[i] = 8'hFF; x[i] = 8'h7F; end
    load_ops(32'd10, w, x);
    wr(32'h00, 32'h1, r);
    wait_done(nb);
    rd(32'h08, v, r);
    check("neg_result", v, 32'hFFFFFB93);
    rd(32'h10, v, r);
    check("w0_sext", v, 32'hFFFFFFFF);

    // Accumulator wraps past the positive limit.
    for (int i = 0; i < 9; i++) begin w[i] = 8'h0; x[i] = 8'h0; end
    w[0] = 8'd1; x[0] = 8'd1;
    load_ops(32'h7FFFFFFF, w, x);
    wr(32'h00, 32'h3, r);
    wait_done(nb);
    rd(32'h08, v, r);
    check("wrap_result", v, 32'h80000000);

    // Illegal accesses.
    cycle(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h10, 32'h55, v, r);
    check("byte_wr_er", {30'b0, r}, {30'b0, R_ER});
    rd(32'h10, v, r);
    check("w0_unchanged", v, 32'h1);
    rd(32'h34, v, r);
    check("unmapped_er", {30'b0, r}, {30'b0, R_ER});
    wr(32'h08, 32'h1234, r);
    check("wr_result_er", {30'b0, r}, {30'b0, R_ER});
    rd(32'h0E, v, r);
    check("misaligned_er", {30'b0, r}, {30'b0, R_ER});

    // Writes while busy: operands locked, restart ignored.
    for (int i = 0; i < 9; i++) begin w[i] = 8'($urandom()); x[i] = 8'($urandom()); end
    load_ops($urandom(), w, x);
    exp_pre = golden();
    wr(32'h00, 32'h1, r);
    wr(32'h40, 32'h33, r);
    check("busy_wr_x0_er", {30'b0, r}, {30'b0, R_ER});
    wr(32'h00, 32'h1, r);
    check("busy_start_ok", {30'b0, r}, {30'b0, R_OK});
    wait_done(nb);
    check("busy_remaining_cycles", 32'(nb), 32'd7);
    rd(32'h08, v, r);
    check("busy_result", v, exp_pre);

    // Reset in the 4th busy cycle with a read response outstanding.
    wr(32'h00, 32'h1, r);
    idle();
    idle();
    rd(32'h04, v, r);
    check("pre_reset_busy", v, 32'h1);
    rd(32'h08, v, r);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ack", {31'b0, dmem_req_ack}, 32'h0);
    check("abort_resp", {30'b0, dmem_resp}, {30'b0, R_IDLE});
    check("abort_rdata", dmem_rdata, 32'h0);
    check("abort_irq", {31'b0, cnn_irq}, 32'h0);
    model_reset();
    do_reset_release();
    rd(32'h04, v, r);
    check("post_reset_status", v, 32'h0);
    rd(32'h08, v, r);
    check("post_reset_result", v, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int sel = $urandom_range(0, 99);
      if (sel < 25) begin
        idle();
      end else begin
        logic [31:0] a, d, hi;
        type_scr1_mem_width_e wd;
        type_scr1_mem_cmd_e   c;
        hi = $urandom();
        a  = (hi & 32'hFFFFFF00) | offs[$urandom_range(0, offs.size() - 1)];
        if ($urandom_range(0, 99) < 5) a = a | 32'($urandom_range(1, 3));
        wd = ($urandom_range(0, 9) == 0) ? type_scr1_mem_width_e'(2'($urandom_range(0, 1)))
                                         : SCR1_MEM_WIDTH_WORD;
        c  = type_scr1_mem_cmd_e'(1'($urandom_range(0, 1)));
        d  = ((a & 32'hFF) == 32'h0) ? 32'($urandom_range(0, 3)) : $urandom();
        cycle(1, c, wd, a, d, v, r);
      end
    end
    wait_done(nb);
    rd(32'h08, v, r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_scr1_cnn_mac_slave
